ifu_fetch: RTL
==============

// Module: ifu_fetch
// PURPOSE
//   Instruction fetch unit: owns the PC and runs a two-state fetch/execute handshake with
//   instruction memory. Presents one latched instruction per step to the general controller
//   (ctrl) and the datapath. Computes next PC from the controller's Branch/Jump outputs plus
//   the ALU zero flag and rs value.
// PARAMETERS
//   RESET_PC   32'h0000_3000   PC loaded on reset; must be word-aligned
// PORTS
//   clk          in   1   single clock; all state updates on rising edge
//   rst          in   1   synchronous, active-high reset
//   imem_req     out  1   fetch request to instruction memory
//   imem_addr    out  32  fetch address (= pc)
//   imem_rdata   in   32  fetched word, valid when imem_ready=1
//   imem_ready   in   1   memory response strobe; sampled only while imem_req=1
//   instruction  out  32  latched instruction, drives ctrl.instruction
//   instr_valid  out  1   instruction is executing this cycle; datapath may commit
//   pc           out  32  address of current instruction
//   pc_plus4     out  32  pc+4; link value for jal/jalr (Link)
//   branch       in   1   ctrl.Branch
//   jump         in   1   ctrl.Jump (j/jal)
//   jump_reg     in   1   jr/jalr decoded (op=0, funct=6'b001000/001001)
//   zero         in   1   ALU zero flag; branch taken when branch&zero
//   rs_data      in   32  register rs; jr target
//   hold         in   1   datapath stall; freezes EXEC
//   fault        out  1   sticky misaligned-target trap
//   instret      out  32  retired-instruction counter
// BEHAVIOUR
//   - Reset (rst=1 at edge): pc<=RESET_PC, instruction<=0, state<=FETCH, fault<=0, instret<=0.
//     While rst=1, imem_req=0 and instr_valid=0 (combinationally forced).
//   - FSM states FETCH, EXEC, TRAP; encoded 2 bits.
//     FETCH: imem_req=1, imem_addr=pc, instr_valid=0. On imem_ready: instruction<=imem_rdata,
//            -> EXEC. Without ready: stay; no timeout; imem_addr stable.
//     EXEC:  imem_req=0, instr_valid=1. If hold: stay, no state change.
//            Else if next_pc[1:0]!=0: fault<=1, pc unchanged, -> TRAP.
//            Else pc<=next_pc, instret<=instret+1 (wraps 32'hFFFF_FFFF->0), -> FETCH.
//     TRAP:  imem_req=0, instr_valid=0; exits only via rst.
//   - Minimum 2 cycles/instruction (zero-wait memory); latency fetch-issue to valid = 1+wait.
//   - next_pc priority: jump_reg > jump > (branch&zero) > pc+4.
//       jr target     = rs_data
//       jump target   = {pc_plus4[31:28], instruction[25:0], 2'b00}
//       branch target = pc_plus4 + ({{14{instruction[15]}}, instruction[15:0], 2'b00})
//     32-bit modular arithmetic; wrap at 32'hFFFF_FFFC+4 -> 0 without flag.
//   - Simultaneous jump & branch: jump wins. jump_reg with jump: jump_reg wins.
//   - Only jr can misalign (other targets have [1:0]=00 by construction).
//   - Reset mid-FETCH: request dropped same cycle; memory must tolerate abandoned request;
//     imem_ready arriving in the reset cycle is ignored.
//   - Reset mid-EXEC with hold=1: reset dominates; instret not incremented.
//   - instruction, pc stable throughout EXEC including hold cycles.
// STRUCTURE
//   - Shared package cpu_defs: FSM state encodings, RESET_PC default, FUNCT_JR/FUNCT_JALR,
//     OP_J/OP_JAL constants (shared with ctrl decode).
//   - One sub-module: npc_calc (combinational next-PC mux + target adders; inputs pc,
//     instruction, rs_data, branch, jump, jump_reg, zero; outputs next_pc, pc_plus4).
//   - ifu_fetch holds FSM, pc/instruction registers, fault, instret.
// TESTING
//   1. Reset, memory ready every cycle with nops -> imem_addr 0x3000,0x3004,0x3008 on
//      alternating FETCH cycles; instret=3 after 6 cycles.
//   2. beq at 0x3000, imm16=16'hFFFF, zero=1 -> next fetch 0x3000; zero=0 -> 0x3004.
//   3. j at 0x3000 with instr[25:0]=26'h0000C10 -> next imem_addr 0x0000_3040; jump&branch
//      both high -> jump target used.
//   4. jr with rs_data=32'h0000_3102 -> fault=1, state TRAP, imem_req stays 0, pc=0x3000,
//      instret unchanged; rst clears fault, fetch resumes at 0x3000.
//   5. imem_ready low 3 cycles in FETCH, then hold=1 for 2 EXEC cycles -> imem_addr stable,
//      instruction/pc stable, instret increments exactly once.
//   6. rst asserted in FETCH cycle with imem_ready=1 -> instruction stays 0, pc=0x3000,
//      instr_valid never asserted that cycle.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions for the fetch unit and the controller decode.
//   - Fetch FSM state encodings (2 bits, exposed on the fetch debug port).
//   - Default reset PC.
//   - Opcode/funct constants for j/jal/jr/jalr, shared with ctrl decode.
//   - branch_offset(): sign-extended, word-scaled branch displacement.
package cpu_defs;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // Fetch FSM state encodings
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_TRAP  = 2'd2;

  // Decode constants shared with the general controller
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] FUNCT_JR   = 6'b001000;
  localparam logic [5:0] FUNCT_JALR = 6'b001001;

  // imm16 sign-extended and shifted left by two (word displacement -> bytes)
  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection.
// Ports:
//   pc          in  32  address of the executing instruction
//   instruction in  32  executing instruction (index/imm fields used)
//   rs_data     in  32  register rs, target for jr/jalr
//   branch      in  1   ctrl.Branch
//   jump        in  1   ctrl.Jump (j/jal)
//   jump_reg    in  1   jr/jalr decoded
//   zero        in  1   ALU zero flag
//   next_pc     out 32  selected next PC (may be misaligned only via rs_data)
//   pc_plus4    out 32  pc + 4, also the link value
// Priority: jump_reg > jump > (branch & zero) > pc + 4. All arithmetic is
// 32-bit modular; wrap-around past 32'hFFFF_FFFC is not flagged.
module npc_calc
  import cpu_defs::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instruction,
  input  logic [31:0] rs_data,
  input  logic        branch,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic        zero,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4
);

  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic        unused_opcode;

  assign pc_plus4      = pc + 32'd4;
  // Pseudo-direct jump: keep the region bits of the delay-slot address
  assign jump_target   = {pc_plus4[31:28], instruction[25:0], 2'b00};
  assign branch_target = pc_plus4 + branch_offset(instruction[15:0]);
  // Opcode bits are decoded by ctrl, not here
  assign unused_opcode = ^instruction[31:26];

  always_comb begin
    next_pc = pc_plus4;
    if (jump_reg) begin
      next_pc = rs_data;
    end else if (jump) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC and runs a FETCH/EXEC handshake with
// instruction memory, presenting one latched instruction per step.
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   imem_req      out 1   fetch request (FETCH state, not in reset)
//   imem_addr     out 32  fetch address, always equal to pc
//   imem_rdata    in  32  fetched word, valid with imem_ready
//   imem_ready    in  1   response strobe, only looked at while imem_req=1
//   instruction   out 32  latched instruction for ctrl/datapath
//   instr_valid   out 1   EXEC state: datapath may commit this cycle
//   pc, pc_plus4  out 32  current instruction address and its link value
//   branch, jump, jump_reg, zero, rs_data   in  next-PC controls
//   hold          in  1   datapath stall, freezes EXEC
//   fault         out 1   sticky misaligned-target trap
//   instret       out 32  retired-instruction counter (wraps)
//   state_dbg     out 2   current FSM state (cpu_defs ST_* encoding)
// Handshake: a fetch completes on any rising edge where imem_req=1 and
// imem_ready=1; the word is captured at that edge. There is no timeout and
// imem_addr is held stable while waiting. A request abandoned by reset is
// simply dropped; a ready strobe in the reset cycle is ignored.
module ifu_fetch
  import cpu_defs::*;
#(
  // Must be word-aligned
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        branch,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic        zero,
  input  logic [31:0] rs_data,
  input  logic        hold,
  output logic        fault,
  output logic [31:0] instret,
  output logic [1:0]  state_dbg
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        fault_q, fault_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] next_pc;

  npc_calc u_npc_calc (
    .pc          (pc_q),
    .instruction (instr_q),
    .rs_data     (rs_data),
    .branch      (branch),
    .jump        (jump),
    .jump_reg    (jump_reg),
    .zero        (zero),
    .next_pc     (next_pc),
    .pc_plus4    (pc_plus4)
  );

  // Reset forces the strobes low in the same cycle so an in-flight request
  // is dropped immediately.
  assign imem_req    = !rst && (state_q == ST_FETCH);
  assign instr_valid = !rst && (state_q == ST_EXEC);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign fault       = fault_q;
  assign instret     = instret_q;
  assign state_dbg   = state_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    fault_d   = fault_q;
    instret_d = instret_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!hold) begin
          // Only a jr target can be misaligned; trap without advancing pc
          if (next_pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = ST_TRAP;
          end else begin
            pc_d      = next_pc;
            instret_d = instret_q + 32'd1;
            state_d   = ST_FETCH;
          end
        end
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= 32'd0;
      fault_q   <= 1'b0;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      fault_q   <= fault_d;
      instret_q <= instret_d;
    end
  end

endmodule
